// File: rtl/lsu_mem_master.sv
// Load/store initiator for a single-port, word-indexed data memory: byte/half/word
// loads with extension, sub-word stores by read-modify-write. Optional macro LSU_MISALIGN_TRAP_EN.
module lsu_mem_master #(
  parameter int MEM_AW = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t      state_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        we_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic [1:0]  lane_r;
  logic [31:0] wdata_r;

  logic [1:0]  size_norm_s;
  logic [1:0]  lane_s;
  logic        err_s;
  logic [31:0] idx_s;
  logic        unused_addr_s;

  // Pull out the addressed lane of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the word read back from memory.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          2'd3:    r[31:24] = wd[7:0];
          default: r = word;
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) begin
          r[31:16] = wd[15:0];
        end else begin
          r[15:0] = wd[15:0];
        end
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  assign idx_s         = {{(30 - MEM_AW){1'b0}}, i_req_addr[MEM_AW+1:2]};
  assign unused_addr_s = ^i_req_addr[31:MEM_AW+2];

  // Decode request size, aligned lane offset and misalignment error.
  always_comb begin
    size_norm_s = i_req_size;
    lane_s      = i_req_addr[1:0];
    err_s       = 1'b0;
    case (i_req_size)
      SZ_BYTE: lane_s = i_req_addr[1:0];
      SZ_HALF: lane_s = {i_req_addr[1], 1'b0};
      SZ_WORD: lane_s = 2'b00;
      SZ_RSVD: begin
        size_norm_s = SZ_WORD;
        lane_s      = 2'b00;
      end
      default: lane_s = 2'b00;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if ((i_req_size == SZ_HALF && i_req_addr[0]) ||
        (i_req_size == SZ_WORD && i_req_addr[1:0] != 2'b00) ||
        (i_req_size == SZ_RSVD)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
`else
    err_s = 1'b0;
`endif
  end

  // Request/response FSM; every output is driven straight from a register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      we_r        <= 1'b0;
      size_r      <= 2'b00;
      unsigned_r  <= 1'b0;
      lane_r      <= 2'b00;
      wdata_r     <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!req_ready_r) begin
            req_ready_r <= 1'b1;
          end else if (i_req_valid) begin
            req_ready_r <= 1'b0;
            we_r        <= i_req_we;
            size_r      <= size_norm_s;
            unsigned_r  <= i_req_unsigned;
            lane_r      <= lane_s;
            wdata_r     <= i_req_wdata;
            mem_addr_r  <= idx_s;
            if (err_s) begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= 32'h0000_0000;
              state_r     <= ST_RESP;
            end else if (i_req_we && size_norm_s == SZ_WORD) begin
              mem_wdata_r <= i_req_wdata;
              mem_we_r    <= 1'b1;
              state_r     <= ST_WR;
            end else begin
              state_r <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (we_r) begin
            mem_wdata_r <= store_merge(i_mem_rdata, wdata_r, size_r, lane_r);
            mem_we_r    <= 1'b1;
            state_r     <= ST_WR;
          end else begin
            rsp_rdata_r <= load_extend(i_mem_rdata, size_r, lane_r, unsigned_r);
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_WR: begin
          mem_we_r    <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
          rsp_err_r   <= 1'b0;
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
          req_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          mem_we_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = req_ready_r;
  assign o_rsp_valid = rsp_valid_r;
  assign o_rsp_rdata = rsp_rdata_r;
  assign o_rsp_err   = rsp_err_r;
  assign o_mem_we    = mem_we_r;
  assign o_mem_addr  = mem_addr_r;
  assign o_mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master with a 32-word behavioural memory.
`timescale 1ns/1ps
module tb_lsu_mem_master;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  logic [31:0] mem_r [0:31];
  int checks_cnt;
  int errors_cnt;

  lsu_mem_master #(.MEM_AW(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  assign i_mem_rdata = mem_r[o_mem_addr[4:0]];

  // Synchronous memory write port.
  always @(posedge i_clk) begin
    if (o_mem_we) mem_r[o_mem_addr[4:0]] <= o_mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Issue one request and observe until its response (latency counted from the accept edge).
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int we_cycles, output logic [31:0] we_addr, output logic [31:0] we_data);
    int n;
    n = 0;
    lat = 0; rdata = 32'hXXXX_XXXX; err = 1'b0; we_cycles = 0;
    we_addr = 32'h0; we_data = 32'h0;
    while (!o_req_ready && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("ready_before_req", {31'd0, o_req_ready}, 32'd1);
    i_req_we = we; i_req_size = sz; i_req_unsigned = uns;
    i_req_addr = addr; i_req_wdata = wd; i_req_valid = 1'b1;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (o_mem_we) begin
        we_cycles++;
        we_addr = o_mem_addr;
        we_data = o_mem_wdata;
      end
      if (o_rsp_valid) begin
        lat = k; rdata = o_rsp_rdata; err = o_rsp_err;
        break;
      end
      @(posedge i_clk); #1;
    end
    @(posedge i_clk); #1;
    chk("rsp_one_cycle", {31'd0, o_rsp_valid}, 32'd0);
  endtask

  // Run one request and compare latency, data, error and write count.
  task automatic tx(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                    input logic [31:0] addr, input logic [31:0] wd,
                    input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                    input int exp_wes, output logic [31:0] we_addr, output logic [31:0] we_data);
    int lat, wes;
    logic [31:0] rd;
    logic er;
    do_req(we, sz, uns, addr, wd, lat, rd, er, wes, we_addr, we_data);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, rd, exp_rdata);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    chk({tag, "_wecnt"}, wes, exp_wes);
  endtask

  initial begin
    logic [31:0] wa, wdv;
    checks_cnt = 0; errors_cnt = 0;
    i_rst_n = 1'b0; i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'b10;
    i_req_unsigned = 1'b0; i_req_addr = 32'h0000_0010; i_req_wdata = 32'h1234_5678;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", {31'd0, o_req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
    chk("rst_mem_we", {31'd0, o_mem_we}, 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_mem_wdata", o_mem_wdata, 32'd0);
    chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    i_rst_n = 1'b1;
    chk("rel_ready_low", {31'd0, o_req_ready}, 32'd0);
    @(posedge i_clk); #1;
    chk("rel_ready_high", {31'd0, o_req_ready}, 32'd1);
    chk("rel_no_accept", {31'd0, o_mem_we}, 32'd0);
    i_req_valid = 1'b0;

    tx("wst", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, wa, wdv);
    chk("wst_addr", wa, 32'd4);
    chk("wst_data", wdv, 32'hDEADBEEF);
    tx("wld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, wa, wdv);

    tx("pre1", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 2, 32'h0, 1'b0, 1, wa, wdv);
    tx("bst", 1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FFAA, 3, 32'h0, 1'b0, 1, wa, wdv);
    chk("bst_addr", wa, 32'd4);
    chk("bst_data", wdv, 32'h11AA3344);
    tx("bst_rb", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'h11AA3344, 1'b0, 0, wa, wdv);

    tx("pre2", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8000F0FF, 2, 32'h0, 1'b0, 1, wa, wdv);
    tx("lb_s0", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 2, 32'hFFFFFFFF, 1'b0, 0, wa, wdv);
    tx("lb_u0", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 2, 32'h000000FF, 1'b0, 0, wa, wdv);
    tx("lh_s2", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 32'hFFFF8000, 1'b0, 0, wa, wdv);
    tx("lh_u2", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 32'h00008000, 1'b0, 0, wa, wdv);
    tx("lb_s1", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 2, 32'hFFFFFFF0, 1'b0, 0, wa, wdv);
    tx("lb_s3", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 32'hFFFFFF80, 1'b0, 0, wa, wdv);
    tx("lh_u0", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 2, 32'h0000F0FF, 1'b0, 0, wa, wdv);

`ifdef LSU_MISALIGN_TRAP_EN
    tx("mis_wld", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1, 0, wa, wdv);
    tx("mis_hst", 1'b1, 2'b01, 1'b0, 32'h11, 32'h5555, 1, 32'h0, 1'b1, 0, wa, wdv);
    tx("rsv_ld", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, wa, wdv);
    tx("mis_rb", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'h8000F0FF, 1'b0, 0, wa, wdv);
`else
    tx("mis_wld", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 2, 32'h8000F0FF, 1'b0, 0, wa, wdv);
    tx("mis_lh", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 2, 32'hFFFF8000, 1'b0, 0, wa, wdv);
    tx("rsv_ld", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 2, 32'h8000F0FF, 1'b0, 0, wa, wdv);
`endif

    tx("hst", 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 3, 32'h0, 1'b0, 1, wa, wdv);
    chk("hst_data", wdv, 32'h1234F0FF);

    tx("wrap", 1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFEF00D, 2, 32'h0, 1'b0, 1, wa, wdv);
    chk("wrap_addr", wa, 32'd0);
    tx("wrap_rb", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 2, 32'hCAFEF00D, 1'b0, 0, wa, wdv);

    // Reset while a half store is in WR.
    tx("pre3", 1'b1, 2'b10, 1'b0, 32'h18, 32'h55667788, 2, 32'h0, 1'b0, 1, wa, wdv);
    i_req_we = 1'b1; i_req_size = 2'b01; i_req_unsigned = 1'b0;
    i_req_addr = 32'h18; i_req_wdata = 32'h0000ABCD; i_req_valid = 1'b1;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("abort_in_wr", {31'd0, o_mem_we}, 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("abort_we_drop", {31'd0, o_mem_we}, 32'd0);
    chk("abort_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    chk("abort_rel_rsp", {31'd0, o_rsp_valid}, 32'd0);
    @(posedge i_clk); #1;
    chk("abort_ready", {31'd0, o_req_ready}, 32'd1);
    chk("abort_rsp2", {31'd0, o_rsp_valid}, 32'd0);
    tx("abort_rb", 1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 2, 32'h55667788, 1'b0, 0, wa, wdv);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the single-port word-indexed data memory from the CPU pipeline side.
- Memory interface:
  - write enable, word address and write data are registered outputs;
  - read data is sampled the cycle after the address is driven (memory read is combinational, write is synchronous on posedge with we).
- Accepts byte/half/word loads and stores through a valid/ready request port and returns one response per request.
- Sign/zero extension on loads; read-modify-write merge on sub-word stores.

Parameters:
- MEM_AW, 5, number of word-index bits driven on o_mem_addr. Byte-address bits above [MEM_AW+1] are dropped, so the index wraps modulo 2^MEM_AW.

Ports:
- i_clk  input  1  clock; all state changes on posedge
- i_rst_n  input  1  asynchronous active-low reset
- i_req_valid  input  1  request present
- o_req_ready  output  1  block can accept a request
- i_req_we  input  1  1 = store, 0 = load
- i_req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- i_req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- i_req_addr  input  32  byte address
- i_req_wdata  input  32  store data; the value is in the low bits for byte/half stores
- o_rsp_valid  output  1  one-cycle response pulse
- o_rsp_rdata  output  32  extended load data; 0 for stores and errors
- o_rsp_err  output  1  request rejected; qualified by o_rsp_valid
- o_mem_we  output  1  memory write enable
- o_mem_addr  output  32  word index = addr[MEM_AW+1:2], zero-extended to 32 bits
- o_mem_wdata  output  32  full word to write
- i_mem_rdata  input  32  word at o_mem_addr, valid in the same cycle

Behaviour:
- Reset:
  - Async: every register clears immediately while i_rst_n = 0.
  - State IDLE; o_req_ready = 0; o_rsp_valid, o_rsp_err, o_mem_we = 0; o_mem_addr, o_mem_wdata, o_rsp_rdata = 0.
  - o_req_ready rises at the first posedge after reset release.
- Reset mid-operation aborts the access. o_mem_we drops asynchronously, so no partial write lands, and no response is issued.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - o_req_ready = 1. Accept occurs on a posedge with i_req_valid & o_req_ready (cycle N).
  - On accept: latch the request, clear o_req_ready, drive o_mem_addr.
  - Next state:
    - load or sub-word store -> RD
    - word store -> WR, with o_mem_wdata = i_req_wdata and o_mem_we = 1
- RD (o_mem_we = 0):
  - At the posedge, capture i_mem_rdata.
  - Load: extract the lane, extend it, -> RESP.
  - Sub-word store: merge the store lane into the captured word, o_mem_wdata = merged word, o_mem_we = 1, -> WR.
- WR: the memory writes at the posedge; o_mem_we clears; -> RESP.
- RESP:
  - o_rsp_valid = 1 for exactly one cycle, with o_rsp_rdata/o_rsp_err valid.
  - -> IDLE and o_req_ready = 1 at the next posedge.
  - No response backpressure.
- Latency (o_rsp_valid high in cycle):
  - load: N+2
  - word store: N+2
  - sub-word store: N+3
  - error: N+1
- Lanes are little-endian:
  - byte k = bits [8k+7:8k], k = addr[1:0]
  - half = bits [16h+15:16h], h = addr[1]
- Merge replaces only the addressed lane; all other lanes keep the value read in RD.
- Size 11 is treated as word.
- Inputs are ignored while o_req_ready = 0. A valid asserted during reset is not accepted.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - A half with addr[0] = 1 or a word with addr[1:0] != 0, or size 11, goes IDLE -> RESP directly.
  - o_rsp_err = 1, o_rsp_rdata = 0, no memory access (o_mem_we stays 0).
- Undefined:
  - Never errors (o_rsp_err tied 0).
  - Misaligned addresses are forced aligned: half clears addr[0]; word clears addr[1:0].

Test Plan:
- Word store 0xDEADBEEF @ 0x10, then word load @ 0x10:
  - o_mem_addr = 4 and o_mem_we = 1 for one cycle, rsp at N+2;
  - load returns 0xDEADBEEF at N+2.
- Memory word 4 = 0x11223344, byte store 0xAA @ 0x12 -> RD then WR with o_mem_wdata = 0x11AA3344, rsp at N+3.
- Memory word 4 = 0x8000F0FF:
  - signed byte load @ 0x10 -> 0xFFFFFFFF;
  - unsigned byte load @ 0x10 -> 0x000000FF;
  - signed half load @ 0x12 -> 0xFFFF8000.
- Word load @ 0x13:
  - with LSU_MISALIGN_TRAP_EN: o_rsp_err = 1 at N+1, o_mem_we never 1;
  - without it: reads word 4.
- Address wrap: word store @ 0x80 (MEM_AW = 5) -> o_mem_addr = 0.
- Assert i_rst_n = 0 during WR of a half store -> o_mem_we drops immediately, memory unchanged, no o_rsp_valid; o_req_ready = 1 one cycle after release.
